rf_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage register file: multi-port architectural register file plus per-register pending-write counter scoreboard.
- Sits between decode/issue, which reserves destinations and reads operands, and commit, which retires results.
- Unlike the single-busy-bit design, it tracks several outstanding writes per register, retires several commits per cycle with same-cycle bypass, and supports a global flush.
- All state updates occur on the rising edge only.

---
 rtl/rf_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_rf_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Multi-port architectural register file with a per-register pending-write
// counter scoreboard. Decode reserves destinations (issue) and reads operands;
// commit retires results with same-cycle bypass. A flush drops all pending counts.

// One read lane: operand mux (zero / bypass / array) plus RAW hazard detect.
module rf_scoreboard_rd #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NCMT = 2,
  parameter int CW   = 2
) (
  input  logic                           ena,
  input  logic [AW-1:0]                  addr,
  input  logic [NCMT-1:0]                cmt_valid,
  input  logic [NCMT-1:0]                cmt_wena,
  input  logic [NCMT-1:0][AW-1:0]        cmt_waddr,
  input  logic [NCMT-1:0][XLEN-1:0]      cmt_wdata,
  input  logic [XLEN-1:0]                reg_val,
  input  logic [CW-1:0]                  cnt_val,
  output logic [XLEN-1:0]                data,
  output logic                           raw
);
  localparam int NW = $clog2(NCMT + 1);

  logic          hit;
  logic [NW-1:0] n;
  logic [XLEN-1:0] byp;

  // Count commits retiring this operand; ascending scan leaves the youngest data.
  always_comb begin
    hit = 1'b0;
    n   = '0;
    byp = '0;
    for (int k = 0; k < NCMT; k++) begin
      if (cmt_valid[k] && cmt_wena[k] && cmt_waddr[k] == addr) begin
        hit = 1'b1;
        n   = n + NW'(1);
        byp = cmt_wdata[k];
      end
    end
  end

  // Operand is ready only once every outstanding write has retired.
  always_comb begin
    data = (!ena || addr == '0) ? '0 : (hit ? byp : reg_val);
    raw  = ena && addr != '0 && (int'(cnt_val) != int'(n));
  end
endmodule

module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 4,
  parameter int NCMT = 2,
  parameter int CW   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic                   issue_wena_i,
  input  logic [AW-1:0]          issue_waddr_i,
  input  logic [NCMT-1:0]        cmt_valid_i,
  input  logic [NCMT-1:0]        cmt_wena_i,
  input  logic [NCMT*AW-1:0]     cmt_waddr_i,
  input  logic [NCMT*XLEN-1:0]   cmt_wdata_i,
  input  logic [NRD-1:0]         rd_ena_i,
  input  logic [NRD*AW-1:0]      rd_addr_i,
  output logic [NRD*XLEN-1:0]    rd_data_o,
  output logic [NRD-1:0]         rd_raw_o,
  output logic                   err_o,
  output logic [XLEN-1:0]        dbg_a0_o
);
  localparam int NW = $clog2(NCMT + 1);
  localparam logic [CW-1:0] CMAX = '1;

  logic [NCMT-1:0][AW-1:0]   cmt_waddr;
  logic [NCMT-1:0][XLEN-1:0] cmt_wdata;
  logic [NREG-1:0][XLEN-1:0] regs, wsel;
  logic [NREG-1:0][CW-1:0]   cnt, cnt_nxt;
  logic [NREG-1:0][NW-1:0]   ncmt;
  logic [NREG-1:0]           whit, under;
  logic                      issue_fire, err;
  int                        s;

  assign cmt_waddr = cmt_waddr_i;
  assign cmt_wdata = cmt_wdata_i;

  // Per-register commit hits: retire count and youngest write data; x0 never hits.
  always_comb begin
    ncmt = '0;
    whit = '0;
    wsel = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NCMT; k++) begin
        if (cmt_valid_i[k] && cmt_wena_i[k] && cmt_waddr[k] == AW'(r)) begin
          ncmt[r] = ncmt[r] + NW'(1);
          whit[r] = 1'b1;
          wsel[r] = cmt_wdata[k];
        end
      end
    end
  end

  // Stall only a write to a saturated counter that no commit is draining now.
  always_comb begin
    issue_ready_o = !(issue_wena_i && issue_waddr_i != '0 &&
                      cnt[issue_waddr_i] == CMAX && ncmt[issue_waddr_i] == '0);
    issue_fire    = issue_valid_i && issue_ready_o;
  end

  // Next pending count: issue and commits net out; going negative clamps to 0.
  always_comb begin
    s       = 0;
    cnt_nxt = '0;
    under   = '0;
    for (int r = 1; r < NREG; r++) begin
      s = int'(cnt[r]) - int'(ncmt[r]) +
          ((issue_fire && issue_wena_i && issue_waddr_i == AW'(r)) ? 1 : 0);
      under[r]   = (s < 0);
      cnt_nxt[r] = (s < 0) ? '0 : CW'(s);
    end
  end

  // State update: commits always write; flush zeroes counters and masks underflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (whit[r]) regs[r] <= wsel[r];
      cnt <= flush_i ? '0 : cnt_nxt;
      if (!flush_i && |under) err <= 1'b1;
    end
  end

  assign err_o    = err;
  assign dbg_a0_o = regs[10];

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr_i[j*AW +: AW];
    rf_scoreboard_rd #(.XLEN(XLEN), .AW(AW), .NCMT(NCMT), .CW(CW)) u_rd (
      .ena       (rd_ena_i[j]),
      .addr      (a),
      .cmt_valid (cmt_valid_i),
      .cmt_wena  (cmt_wena_i),
      .cmt_waddr (cmt_waddr),
      .cmt_wdata (cmt_wdata),
      .reg_val   (regs[a]),
      .cnt_val   (cnt[a]),
      .data      (rd_data_o[j*XLEN +: XLEN]),
      .raw       (rd_raw_o[j])
    );
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized + directed bench for rf_scoreboard: a driver predicts each cycle's
// outputs from a behavioural model and queues them; a monitor compares them.
module tb_rf_scoreboard;
  localparam int XLEN = 32, NREG = 32, AW = 5, NRD = 4, NCMT = 2, CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clock = 1'b0;
  logic                 reset, flush_i, issue_valid_i, issue_ready_o, issue_wena_i;
  logic [AW-1:0]        issue_waddr_i;
  logic [NCMT-1:0]      cmt_valid_i, cmt_wena_i;
  logic [NCMT*AW-1:0]   cmt_waddr_i;
  logic [NCMT*XLEN-1:0] cmt_wdata_i;
  logic [NRD-1:0]       rd_ena_i, rd_raw_o;
  logic [NRD*AW-1:0]    rd_addr_i;
  logic [NRD*XLEN-1:0]  rd_data_o;
  logic                 err_o;
  logic [XLEN-1:0]      dbg_a0_o;

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NCMT(NCMT), .CW(CW)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_wena_i(issue_wena_i), .issue_waddr_i(issue_waddr_i),
    .cmt_valid_i(cmt_valid_i), .cmt_wena_i(cmt_wena_i),
    .cmt_waddr_i(cmt_waddr_i), .cmt_wdata_i(cmt_wdata_i),
    .rd_ena_i(rd_ena_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_raw_o(rd_raw_o),
    .err_o(err_o), .dbg_a0_o(dbg_a0_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NRD-1:0][XLEN-1:0] data;
    logic [NRD-1:0]           raw;
    logic                     ready;
    logic                     err;
    logic [XLEN-1:0]          a0;
    int                       cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model state: architectural values, outstanding-write counts, sticky error.
  logic [XLEN-1:0] m_regs [NREG];
  int              m_cnt  [NREG];
  bit              m_err;
  bit              m_ready;

  // How many commits this cycle retire a write to register a (x0 never counts).
  function automatic int hits(input logic [AW-1:0] a);
    int n = 0;
    if (a == 0) return 0;
    for (int k = 0; k < NCMT; k++)
      if (cmt_valid_i[k] && cmt_wena_i[k] && cmt_waddr_i[k*AW +: AW] == a) n++;
    return n;
  endfunction

  // Youngest committing data for register a: scan from the highest port down.
  function automatic logic [XLEN-1:0] youngest(input logic [AW-1:0] a);
    for (int k = NCMT - 1; k >= 0; k--)
      if (cmt_valid_i[k] && cmt_wena_i[k] && cmt_waddr_i[k*AW +: AW] == a)
        return cmt_wdata_i[k*XLEN +: XLEN];
    return '0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [AW-1:0] a;
    e = '0;
    for (int j = 0; j < NRD; j++) begin
      a = rd_addr_i[j*AW +: AW];
      if (rd_ena_i[j] && a != 0) begin
        e.data[j] = (hits(a) > 0) ? youngest(a) : m_regs[a];
        e.raw[j]  = (m_cnt[a] - hits(a)) != 0;
      end
    end
    e.ready = !(issue_wena_i && issue_waddr_i != 0 &&
                m_cnt[issue_waddr_i] == CMAX && hits(issue_waddr_i) == 0);
    e.err = m_err;
    e.a0  = m_regs[10];
    e.cyc = cyc;
    return e;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
    m_err = 1'b0;
  endtask

  // Apply one rising edge with the currently driven inputs.
  task automatic model_edge();
    int d;
    logic [AW-1:0] ra;
    if (reset) begin model_clear(); return; end
    for (int r = 1; r < NREG; r++) begin
      ra = AW'(r);
      if (hits(ra) > 0) m_regs[r] = youngest(ra);
      if (flush_i) m_cnt[r] = 0;
      else begin
        d = m_cnt[r] - hits(ra) +
            ((issue_valid_i && m_ready && issue_wena_i && issue_waddr_i == ra) ? 1 : 0);
        if (d < 0) begin m_cnt[r] = 0; m_err = 1'b1; end
        else m_cnt[r] = d;
      end
    end
  endtask

  task automatic clr();
    flush_i = 0; issue_valid_i = 0; issue_wena_i = 0; issue_waddr_i = '0;
    cmt_valid_i = '0; cmt_wena_i = '0; cmt_waddr_i = '0; cmt_wdata_i = '0;
    rd_ena_i = '0; rd_addr_i = '0;
  endtask

  task automatic issue(input int a);
    issue_valid_i = 1; issue_wena_i = 1; issue_waddr_i = AW'(a);
  endtask

  task automatic cmt(input int k, input int a, input logic [XLEN-1:0] d);
    cmt_valid_i[k] = 1; cmt_wena_i[k] = 1;
    cmt_waddr_i[k*AW +: AW] = AW'(a); cmt_wdata_i[k*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int j, input int a);
    rd_ena_i[j] = 1; rd_addr_i[j*AW +: AW] = AW'(a);
  endtask

  // One cycle: queue the expected outputs, clock, then advance the model.
  task automatic step(input bit chk = 1);
    exp_t e;
    e = predict();
    m_ready = e.ready;
    if (chk) exp_q.push_back(e);
    @(posedge clock);
    #1;
    model_edge();
    cyc++;
  endtask

  task automatic chk(input string nm, input int c, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so each queued cycle is checked mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int j = 0; j < NRD; j++) begin
        chk($sformatf("rd_data[%0d]", j), e.cyc, rd_data_o[j*XLEN +: XLEN], e.data[j]);
        chk($sformatf("rd_raw[%0d]", j), e.cyc, XLEN'(rd_raw_o[j]), XLEN'(e.raw[j]));
      end
      chk("issue_ready", e.cyc, XLEN'(issue_ready_o), XLEN'(e.ready));
      chk("err", e.cyc, XLEN'(err_o), XLEN'(e.err));
      chk("dbg_a0", e.cyc, dbg_a0_o, e.a0);
    end
  end

  initial begin
    clr();
    reset = 1; m_ready = 1;
    model_clear();
    step(0); step(0);
    reset = 0;

    // Reset state: x5 on every port.
    for (int j = 0; j < NRD; j++) rd(j, 5);
    step();
    // Two pending writes to x5, retire one with bypass, then the last.
    clr(); issue(5); step(); step();
    clr(); cmt(0, 5, 32'h11); rd(0, 5); step();
    clr(); cmt(0, 5, 32'h22); rd(0, 5); step();
    clr(); rd(0, 5); step();
    // Both ports commit x7 in one cycle: youngest wins, count drops by two.
    clr(); issue(7); step(); step();
    clr(); cmt(0, 7, 32'hAAAA); cmt(1, 7, 32'hBBBB); rd(0, 7); rd(1, 7); step();
    clr(); rd(0, 7); step();
    // Saturate x9, stall, then offer again alongside a draining commit.
    clr(); issue(9); step(); step(); step();
    step();
    clr(); issue(9); cmt(0, 9, 32'h99); rd(2, 9); step();
    clr(); rd(2, 9); step();
    // Flush with a concurrent commit, then an unmatched commit sets err.
    clr(); issue(3); step(); clr(); issue(4); step();
    clr(); flush_i = 1; cmt(0, 3, 32'h5); rd(0, 4); rd(1, 3); step();
    clr(); rd(0, 4); rd(1, 3); step();
    clr(); cmt(1, 4, 32'h44); rd(0, 4); step();
    clr(); rd(0, 4); step();
    // x0 traffic is inert.
    clr(); issue(0); cmt(0, 0, 32'hDEAD); rd(0, 0); rd(1, 0); step();
    clr(); rd(0, 0); step();
    // Drive a0 through the commit path.
    clr(); cmt(1, 10, 32'hA0A0_0001); rd(3, 10); step();
    clr(); reset = 1; step(); reset = 0;

    // Random traffic on a narrow address window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      clr();
      reset         = ($urandom_range(0, 199) == 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      issue_valid_i = $urandom_range(0, 1);
      issue_wena_i  = ($urandom_range(0, 3) != 0);
      issue_waddr_i = AW'($urandom_range(0, 11));
      for (int k = 0; k < NCMT; k++) begin
        cmt_valid_i[k] = ($urandom_range(0, 2) == 0);
        cmt_wena_i[k]  = ($urandom_range(0, 4) != 0);
        cmt_waddr_i[k*AW +: AW]     = AW'($urandom_range(0, 11));
        cmt_wdata_i[k*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRD; j++) begin
        rd_ena_i[j] = ($urandom_range(0, 3) != 0);
        rd_addr_i[j*AW +: AW] = AW'($urandom_range(0, 11));
      end
      step();
    end
    clr();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
